// File: rtl/vec_vset_issue.sv
// Issue side of the vector CSR configuration path: decodes vsetvli/vsetivli/vsetvl,
// computes the new vl/vtype, writes the CSR file and returns vl to the scalar core.
module vec_vset_issue #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned VLEN         = 512,
   parameter int unsigned DONE_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            inst_valid,
   output logic            inst_ready,
   input  logic [XLEN-1:0] inst,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] cur_vl,
   output logic            csrwr_en,
   output logic [XLEN-1:0] scalar1,
   output logic [XLEN-1:0] scalar2,
   input  logic            csr_done,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            resp_illegal,
   output logic            resp_timeout
);

   localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CALC, WRITE, WAIT_DONE, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   inst_q, rs1_q, rs2_q, cur_vl_q;
   logic [XLEN-1:0]   vl_q, vl_d;
   logic [7:0]        vtype_q, vtype_d;
   logic              illegal_q, illegal_d;

   logic              inst_ready_d, csrwr_en_d, resp_valid_d, resp_illegal_d, resp_timeout_d;
   logic [XLEN-1:0]   scalar1_d, scalar2_d, rd_data_d;
   logic [4:0]        rd_addr_d;

   // Decode of the captured instruction
   logic              is_vli_c, is_vi_c, is_vl_c, is_vset_c, vtype_ok_c;
   logic [XLEN-1:0]   vtype_raw_c, vlmax_c, avl_c, new_vl_c;
   logic [2:0]        sew_sh_c;

   always_comb begin
      is_vli_c  = (inst_q[31] == 1'b0);
      is_vi_c   = (inst_q[31:30] == 2'b11);
      is_vl_c   = (inst_q[31:25] == 7'b1000000);
      is_vset_c = (inst_q[6:0] == 7'h57) && (inst_q[14:12] == 3'b111)
                  && (is_vli_c || is_vi_c || is_vl_c);

      if (is_vli_c)
         vtype_raw_c = XLEN'(inst_q[30:20]);
      else if (is_vi_c)
         vtype_raw_c = XLEN'(inst_q[29:20]);
      else
         vtype_raw_c = rs2_q;

      vtype_ok_c = ((vtype_raw_c >> 8) == '0) && !vtype_raw_c[2] && (vtype_raw_c[5:3] <= 3'b011);

      // vlmax = VLEN / (8 << vsew) * (1 << vlmul); only meaningful for a legal vtype
      sew_sh_c = 3'd3 + {1'b0, vtype_raw_c[4:3]};
      vlmax_c  = (XLEN'(VLEN) >> sew_sh_c) << vtype_raw_c[1:0];

      if (is_vi_c)
         avl_c = XLEN'(inst_q[19:15]);
      else if (inst_q[19:15] != 5'd0)
         avl_c = rs1_q;
      else if (inst_q[11:7] != 5'd0)
         avl_c = vlmax_c;
      else
         avl_c = cur_vl_q;

      new_vl_c = (avl_c < vlmax_c) ? avl_c : vlmax_c;
   end

   // Next-state and registered-output values
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      vl_d           = vl_q;
      vtype_d        = vtype_q;
      illegal_d      = illegal_q;
      csrwr_en_d     = 1'b0;
      scalar1_d      = scalar1;
      scalar2_d      = scalar2;
      resp_valid_d   = resp_valid;
      rd_addr_d      = rd_addr;
      rd_data_d      = rd_data;
      resp_illegal_d = resp_illegal;
      resp_timeout_d = resp_timeout;

      case (state_q)
         IDLE: begin
            if (inst_valid) state_d = CALC;
         end
         CALC: begin
            if (!is_vset_c) begin
               vl_d           = '0;
               vtype_d        = '0;
               illegal_d      = 1'b1;
               resp_valid_d   = 1'b1;
               rd_addr_d      = inst_q[11:7];
               rd_data_d      = '0;
               resp_illegal_d = 1'b1;
               resp_timeout_d = 1'b0;
               state_d        = RESP;
            end else begin
               // An illegal vtype still reaches the CSR file, as vl=0/vtype=0
               vl_d       = vtype_ok_c ? new_vl_c : '0;
               vtype_d    = vtype_ok_c ? vtype_raw_c[7:0] : 8'd0;
               illegal_d  = !vtype_ok_c;
               csrwr_en_d = 1'b1;
               scalar1_d  = vl_d;
               scalar2_d  = XLEN'(vtype_d);
               state_d    = WRITE;
            end
         end
         WRITE: begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (csr_done || (cnt_q == CNT_W'(DONE_TIMEOUT - 1))) begin
               resp_valid_d   = 1'b1;
               rd_addr_d      = inst_q[11:7];
               rd_data_d      = vl_q;
               resp_illegal_d = illegal_q;
               resp_timeout_d = !csr_done;
               state_d        = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d   = 1'b0;
               resp_illegal_d = 1'b0;
               resp_timeout_d = 1'b0;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      inst_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         inst_q       <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         cur_vl_q     <= '0;
         vl_q         <= '0;
         vtype_q      <= '0;
         illegal_q    <= 1'b0;
         inst_ready   <= 1'b1;
         csrwr_en     <= 1'b0;
         scalar1      <= '0;
         scalar2      <= '0;
         resp_valid   <= 1'b0;
         rd_addr      <= '0;
         rd_data      <= '0;
         resp_illegal <= 1'b0;
         resp_timeout <= 1'b0;
      end else begin
         if (state_q == IDLE && inst_valid) begin
            inst_q   <= inst;
            rs1_q    <= rs1_data;
            rs2_q    <= rs2_data;
            cur_vl_q <= cur_vl;
         end
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vl_q         <= vl_d;
         vtype_q      <= vtype_d;
         illegal_q    <= illegal_d;
         inst_ready   <= inst_ready_d;
         csrwr_en     <= csrwr_en_d;
         scalar1      <= scalar1_d;
         scalar2      <= scalar2_d;
         resp_valid   <= resp_valid_d;
         rd_addr      <= rd_addr_d;
         rd_data      <= rd_data_d;
         resp_illegal <= resp_illegal_d;
         resp_timeout <= resp_timeout_d;
      end
   end

endmodule

// File: tb/tb_vec_vset_issue.sv
// Self-checking bench for vec_vset_issue: directed cases plus randomized instructions
// checked against an arithmetic reference model of the vset rules.
module tb_vec_vset_issue;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned VLEN         = 512;
   localparam int unsigned DONE_TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              inst_valid;
   logic              inst_ready;
   logic [XLEN-1:0]   inst;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic [XLEN-1:0]   cur_vl;
   logic              csrwr_en;
   logic [XLEN-1:0]   scalar1;
   logic [XLEN-1:0]   scalar2;
   logic              csr_done;
   logic              resp_valid;
   logic              resp_ready;
   logic [4:0]        rd_addr;
   logic [XLEN-1:0]   rd_data;
   logic              resp_illegal;
   logic              resp_timeout;

   int checks   = 0;
   int failures = 0;
   logic [31:0] last_s1 = '0;
   logic [31:0] last_s2 = '0;

   always #5 clk = ~clk;

   vec_vset_issue #(.XLEN(XLEN), .VLEN(VLEN), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
      .clk(clk), .n_rst(n_rst),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .cur_vl(cur_vl),
      .csrwr_en(csrwr_en), .scalar1(scalar1), .scalar2(scalar2), .csr_done(csr_done),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .rd_addr(rd_addr), .rd_data(rd_data),
      .resp_illegal(resp_illegal), .resp_timeout(resp_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: vset semantics from the architectural rules
   function automatic void ref_model(input logic [31:0] ins, input logic [31:0] rs1v,
                                     input logic [31:0] rs2v, input logic [31:0] curv,
                                     output bit vset, output bit ill,
                                     output logic [31:0] vl, output logic [31:0] vt);
      int unsigned kind;
      longint unsigned vtype, avl, vlmax, sew, lmul, lcode, scode;
      logic [4:0] rs1f, rdf;
      vset = 0; ill = 0; vl = '0; vt = '0;
      if (ins[6:0] != 7'h57 || ins[14:12] != 3'b111) kind = 0;
      else if (ins[31] == 1'b0) kind = 1;
      else if (ins[30] == 1'b1) kind = 2;
      else if (ins[29:25] == 5'd0) kind = 3;
      else kind = 0;
      if (kind == 0) begin
         ill = 1;
         return;
      end
      vset = 1;
      if (kind == 1) vtype = longint'(ins[30:20]);
      else if (kind == 2) vtype = longint'(ins[29:20]);
      else vtype = longint'(rs2v);
      lcode = vtype % 8;
      scode = (vtype / 8) % 8;
      if (vtype > 255 || lcode > 3 || scode > 3) begin
         ill = 1;
         return;
      end
      sew   = 8 << scode;
      lmul  = 1 << lcode;
      vlmax = (VLEN / sew) * lmul;
      rs1f  = ins[19:15];
      rdf   = ins[11:7];
      if (kind == 2) avl = longint'(rs1f);
      else if (rs1f != 5'd0) avl = longint'(rs1v);
      else if (rdf != 5'd0) avl = vlmax;
      else avl = longint'(curv);
      vl = 32'((avl < vlmax) ? avl : vlmax);
      vt = 32'(vtype);
   endfunction

   // One instruction end to end; done_dly<0 means csr_done never comes
   task automatic run_txn(input string tag, input logic [31:0] ins, input logic [31:0] rs1v,
                          input logic [31:0] rs2v, input logic [31:0] curv,
                          input int done_dly, input int rdy_dly, input bit stray);
      bit vset, ill, exp_to;
      logic [31:0] evl, evt;
      int n;
      ref_model(ins, rs1v, rs2v, curv, vset, ill, evl, evt);
      n = 0;
      while (inst_ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check({tag, ".ready"}, 32'(inst_ready), 32'd1);
      inst = ins; rs1_data = rs1v; rs2_data = rs2v; cur_vl = curv; inst_valid = 1'b1;
      step();
      inst_valid = 1'b0;
      inst = $urandom; rs1_data = $urandom; rs2_data = $urandom; cur_vl = $urandom;
      check({tag, ".c1_ready"}, 32'(inst_ready), 32'd0);
      check({tag, ".c1_wr"}, 32'(csrwr_en), 32'd0);
      step();
      exp_to = 0;
      if (vset) begin
         check({tag, ".wr"}, 32'(csrwr_en), 32'd1);
         check({tag, ".s1"}, scalar1, evl);
         check({tag, ".s2"}, scalar2, evt);
         last_s1 = evl;
         last_s2 = evt;
         if (stray) csr_done = 1'b1;
         step();
         csr_done = 1'b0;
         check({tag, ".wr_pulse"}, 32'(csrwr_en), 32'd0);
         if (done_dly < 0) begin
            exp_to = 1;
            for (int k = 0; k < int'(DONE_TIMEOUT); k++) begin
               check({tag, ".wait_rv"}, 32'(resp_valid), 32'd0);
               step();
            end
         end else begin
            for (int k = 0; k < done_dly; k++) begin
               check({tag, ".wait_rv"}, 32'(resp_valid), 32'd0);
               step();
            end
            csr_done = 1'b1;
            step();
            csr_done = 1'b0;
         end
      end else begin
         check({tag, ".nowr"}, 32'(csrwr_en), 32'd0);
         check({tag, ".s1_hold"}, scalar1, last_s1);
         check({tag, ".s2_hold"}, scalar2, last_s2);
      end
      for (int k = 0; k <= rdy_dly; k++) begin
         check({tag, ".rv"}, 32'(resp_valid), 32'd1);
         check({tag, ".rd_addr"}, 32'(rd_addr), 32'(ins[11:7]));
         if (vset) check({tag, ".rd_data"}, rd_data, evl);
         check({tag, ".illegal"}, 32'(resp_illegal), 32'(ill));
         check({tag, ".timeout"}, 32'(resp_timeout), 32'(exp_to));
         check({tag, ".resp_ready0"}, 32'(inst_ready), 32'd0);
         if (k == rdy_dly) resp_ready = 1'b1;
         step();
      end
      resp_ready = 1'b0;
      check({tag, ".rv_clr"}, 32'(resp_valid), 32'd0);
      check({tag, ".flags_clr"}, 32'({resp_illegal, resp_timeout}), 32'd0);
      check({tag, ".ready_back"}, 32'(inst_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".inst_ready"}, 32'(inst_ready), 32'd1);
      check({tag, ".csrwr_en"}, 32'(csrwr_en), 32'd0);
      check({tag, ".scalar1"}, scalar1, 32'd0);
      check({tag, ".scalar2"}, scalar2, 32'd0);
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
      check({tag, ".rd_data"}, rd_data, 32'd0);
      check({tag, ".flags"}, 32'({resp_illegal, resp_timeout}), 32'd0);
   endtask

   function automatic logic [31:0] mk_vli(input logic [10:0] zimm, input logic [4:0] rs1f, input logic [4:0] rd);
      return {1'b0, zimm, rs1f, 3'b111, rd, 7'h57};
   endfunction
   function automatic logic [31:0] mk_vi(input logic [9:0] zimm, input logic [4:0] uimm, input logic [4:0] rd);
      return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
   endfunction
   function automatic logic [31:0] mk_vl(input logic [4:0] rs2f, input logic [4:0] rs1f, input logic [4:0] rd);
      return {7'b1000000, rs2f, rs1f, 3'b111, rd, 7'h57};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired before the end of stimulus");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins, r1, r2, cv;
      logic [7:0]  vt8;
      int kind, dd;
      n_rst = 1'b0; inst_valid = 1'b0; inst = '0; rs1_data = '0; rs2_data = '0;
      cur_vl = '0; csr_done = 1'b0; resp_ready = 1'b0;
      repeat (3) step();
      check_reset_outputs("rst");
      n_rst = 1'b1;
      step();

      // Directed cases
      run_txn("vli_e32m1", mk_vli(11'h010, 5'd1, 5'd5), 32'd100, 32'd0, 32'd0, 0, 0, 0);
      run_txn("vi_e8m2", mk_vi(10'h001, 5'd10, 5'd6), 32'hDEAD, 32'd0, 32'd0, 1, 0, 1);
      run_txn("vl_vlmax", mk_vl(5'd2, 5'd0, 5'd3), 32'd0, 32'h1B, 32'd0, 0, 1, 0);
      run_txn("vli_keep", mk_vli(11'h008, 5'd0, 5'd0), 32'd999, 32'd0, 32'd7, 2, 0, 0);
      run_txn("bad_op", 32'h0073_02B3, 32'd5, 32'd0, 32'd0, 0, 0, 0);
      run_txn("bad_sew", mk_vli(11'h028, 5'd4, 5'd9), 32'd50, 32'd0, 32'd0, 0, 0, 0);
      run_txn("bad_f7", {7'b1010000, 5'd1, 5'd2, 3'b111, 5'd7, 7'h57}, 32'd5, 32'd3, 32'd0, 0, 2, 0);
      run_txn("vl_hi", mk_vl(5'd2, 5'd1, 5'd3), 32'd5, 32'h100, 32'd0, 0, 0, 0);
      run_txn("timeout", mk_vli(11'h0C3, 5'd2, 5'd11), 32'd1000, 32'd0, 32'd0, -1, 5, 0);

      // Randomized instruction mix
      for (int t = 0; t < 40; t++) begin
         kind = int'($urandom_range(0, 9));
         vt8  = {2'($urandom), 1'b0, 2'($urandom), 1'b0, 2'($urandom)};
         if ($urandom_range(0, 4) == 0) vt8 = 8'($urandom);
         r1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 600)) : $urandom;
         r2 = {24'd0, vt8};
         if ($urandom_range(0, 5) == 0) r2 = $urandom;
         cv = 32'($urandom_range(0, 600));
         case (kind)
            0, 1, 2: ins = mk_vli(($urandom_range(0, 5) == 0) ? 11'($urandom) : {3'b000, vt8},
                                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
            3, 4, 5: ins = mk_vi({2'b00, vt8}, 5'($urandom), 5'($urandom));
            6, 7:    ins = mk_vl(5'($urandom),
                                 ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
            8:       ins = {$urandom} & 32'hFFFF_8F80 | 32'h0000_0033;
            default: ins = {7'b1000001 | 7'($urandom_range(1, 31)), 25'($urandom)} & 32'hFFFF_FF80 | 32'h0000_7057;
         endcase
         dd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
         run_txn("rand", ins, r1, r2, cv, dd, int'($urandom_range(0, 3)),
                 (dd >= 1) && ($urandom_range(0, 1) == 1));
      end

      // Reset while waiting for csr_done
      inst = mk_vli(11'h010, 5'd1, 5'd12); rs1_data = 32'd3; inst_valid = 1'b1;
      step();
      inst_valid = 1'b0;
      step();
      check("mid.wr", 32'(csrwr_en), 32'd1);
      step();
      n_rst = 1'b0;
      step();
      check_reset_outputs("mid");
      n_rst = 1'b1;
      csr_done = 1'b1;
      step();
      csr_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("mid.no_rv", 32'(resp_valid), 32'd0);
         check("mid.no_wr", 32'(csrwr_en), 32'd0);
         check("mid.idle", 32'(inst_ready), 32'd1);
         step();
      end
      last_s1 = '0;
      last_s2 = '0;
      run_txn("post_rst", mk_vi(10'h0D3, 5'd31, 5'd1), 32'd0, 32'd0, 32'd0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
